cos_taylor_sched: RTL and testbench

Sequencing controller that evaluates a Taylor cosine by Horner's rule on one shared `fp_mult2x32` and one shared `fp_adder_2x32`, instead of one unit per term. It accepts one single-precision angle at a time on a valid/ready front end and steps the two units through their stb/ack handshakes. It returns the result on a valid/ready back end. It sits between the angle source and the output formatter in the Taylor cosine path.

---
 rtl/cos_taylor_sched.sv | 198 +++++++++++++++++++
 tb/tb_cos_taylor_sched.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cos_taylor_sched.sv
// cos_taylor_sched
// Horner-rule Taylor cosine sequencer driving one shared fp multiplier and one
// shared fp adder through their stb/ack handshakes.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   in_valid/in_ready/rad    angle input (IEEE-754 single), accepted in IDLE only
//   out_valid/out_ready      result handshake; cosine held while out_valid
//   busy                     high in any state but IDLE
//   mul_* / add_*            operand strobes/acks, result strobe/ack of each unit
//
// Configuration macro: COS_TAYLOR_SCHED_TERM3_EN adds the x^6 term (7 ops
// instead of 5).

module cos_taylor_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] rad,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] cosine,
  output logic        busy,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_a_stb,
  output logic        mul_b_stb,
  input  logic        mul_a_ack,
  input  logic        mul_b_ack,
  input  logic [31:0] mul_z,
  input  logic        mul_z_stb,
  output logic        mul_z_ack,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_a_stb,
  output logic        add_b_stb,
  input  logic        add_a_ack,
  input  logic        add_b_ack,
  input  logic [31:0] add_z,
  input  logic        add_z_stb,
  output logic        add_z_ack
);

  localparam logic [31:0] C1  = 32'hbf000000;  // -1/2
  localparam logic [31:0] C2  = 32'h3d2aaaab;  // 1/24
  localparam logic [31:0] One = 32'h3f800000;
`ifdef COS_TAYLOR_SCHED_TERM3_EN
  localparam logic [31:0] C3       = 32'hbab60b61;  // -1/720
  localparam logic [31:0] CTop     = C3;
  localparam logic [2:0]  LastStep = 3'd6;
`else
  localparam logic [31:0] CTop     = C2;
  localparam logic [2:0]  LastStep = 3'd4;
`endif

  typedef enum logic [2:0] {StIdle, StLoad, StIssue, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] x_q, x_d, x2_q, x2_d, acc_q, acc_d, opa_q, opa_d, opb_q, opb_d;
  logic [2:0]  step_q, step_d;
  logic        a_done_q, a_done_d, b_done_q, b_done_d;

  // Step 0 and odd steps are multiplies; even steps from 2 on are adds.
  logic        use_add;
  assign use_add = (step_q != 3'd0) && !step_q[0];

  logic        a_ack, b_ack, z_stb;
  logic [31:0] z;
  assign a_ack = use_add ? add_a_ack : mul_a_ack;
  assign b_ack = use_add ? add_b_ack : mul_b_ack;
  assign z_stb = use_add ? add_z_stb : mul_z_stb;
  assign z     = use_add ? add_z     : mul_z;

  // Constant added at each add step (Horner coefficients, highest first).
  logic [31:0] add_k;
  always_comb begin
    add_k = One;
`ifdef COS_TAYLOR_SCHED_TERM3_EN
    if (step_q == 3'd2)      add_k = C2;
    else if (step_q == 3'd4) add_k = C1;
`else
    if (step_q == 3'd2)      add_k = C1;
`endif
  end

  logic [31:0] sel_a, sel_b;
  always_comb begin
    sel_a = acc_q;
    sel_b = x2_q;
    if (step_q == 3'd0) begin
      sel_a = x_q;
      sel_b = x_q;
    end else if (step_q == 3'd1) begin
      sel_a = CTop;
    end else if (use_add) begin
      sel_b = add_k;
    end
  end

  logic stb_a, stb_b, z_ack;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    x2_d     = x2_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    step_d   = step_q;
    a_done_d = a_done_q;
    b_done_d = b_done_q;
    stb_a    = 1'b0;
    stb_b    = 1'b0;
    z_ack    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          x_d     = rad;
          step_d  = 3'd0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        opa_d    = sel_a;
        opb_d    = sel_b;
        a_done_d = 1'b0;
        b_done_d = 1'b0;
        state_d  = StIssue;
      end
      StIssue: begin
        // Each strobe falls the cycle after its own ack; leave only once both
        // strobes are already low.
        stb_a    = !a_done_q;
        stb_b    = !b_done_q;
        a_done_d = a_done_q | a_ack;
        b_done_d = b_done_q | b_ack;
        if (a_done_q && b_done_q) state_d = StWait;
      end
      StWait: begin
        if (z_stb) begin
          z_ack = 1'b1;
          if (step_q == 3'd0) x2_d = z;
          else                acc_d = z;
          step_d  = step_q + 3'd1;
          state_d = (step_q == LastStep) ? StDone : StLoad;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      x_q      <= '0;
      x2_q     <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      step_q   <= '0;
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      x2_q     <= x2_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      step_q   <= step_d;
      a_done_q <= a_done_d;
      b_done_q <= b_done_d;
    end
  end

  // Handshake outputs are masked by rst so nothing is strobed or acked while
  // reset is being applied.
  assign in_ready  = rst && (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StDone);
  assign cosine    = (state_q == StDone) ? acc_q : 32'h0;

  assign mul_a     = opa_q;
  assign mul_b     = opb_q;
  assign add_a     = opa_q;
  assign add_b     = opb_q;
  assign mul_a_stb = rst && stb_a && !use_add;
  assign mul_b_stb = rst && stb_b && !use_add;
  assign add_a_stb = rst && stb_a && use_add;
  assign add_b_stb = rst && stb_b && use_add;
  assign mul_z_ack = rst && z_ack && !use_add;
  assign add_z_ack = rst && z_ack && use_add;

endmodule

// File: tb/tb_cos_taylor_sched.sv
module tb_cos_taylor_sched;

  localparam logic [31:0] C1  = 32'hbf000000;
  localparam logic [31:0] C2  = 32'h3d2aaaab;
  localparam logic [31:0] One = 32'h3f800000;
`ifdef COS_TAYLOR_SCHED_TERM3_EN
  localparam logic [31:0] C3   = 32'hbab60b61;
  localparam int          NOps = 7;
  localparam logic [31:0] Cos1 = 32'h3f0a4fa5;
`else
  localparam int          NOps = 5;
  localparam logic [31:0] Cos1 = 32'h3f0aaaab;
`endif
  localparam int MulLat = 4;
  localparam int AddLat = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] rad, cosine;
  logic [31:0] mul_a, mul_b, mul_z, add_a, add_b, add_z;
  logic        mul_a_stb, mul_b_stb, mul_a_ack, mul_b_ack, mul_z_stb, mul_z_ack;
  logic        add_a_stb, add_b_stb, add_a_ack, add_b_ack, add_z_stb, add_z_ack;

  int errors = 0;
  int checks = 0;
  int zacks  = 0;
  int cyc    = 0;
  int a_dly  = 0;
  int b_dly  = 0;

  cos_taylor_sched dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rad       (rad),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cosine    (cosine),
    .busy      (busy),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_a_stb (mul_a_stb),
    .mul_b_stb (mul_b_stb),
    .mul_a_ack (mul_a_ack),
    .mul_b_ack (mul_b_ack),
    .mul_z     (mul_z),
    .mul_z_stb (mul_z_stb),
    .mul_z_ack (mul_z_ack),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_a_stb (add_a_stb),
    .add_b_stb (add_b_stb),
    .add_a_ack (add_a_ack),
    .add_b_ack (add_b_ack),
    .add_z     (add_z),
    .add_z_stb (add_z_stb),
    .add_z_ack (add_z_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- float helpers (normal numbers, denormals flushed) ------
  function automatic real sp2real(input logic [31:0] s);
    if (s[30:23] == 8'd0) return 0.0;
    return $bitstoreal({s[31], 11'(int'(s[30:23]) + 896), s[22:0], 29'b0});
  endfunction

  function automatic logic [31:0] real2sp(input real r);
    logic [63:0] d;
    logic [31:0] m;
    int          e;
    logic        rnd;
    d = $realtobits(r);
    e = int'(d[62:52]) - 896;
    if (e <= 0) return {d[63], 31'b0};
    m   = {1'b0, 8'(e), d[51:29]};
    rnd = d[28] && ((d[27:0] != 28'd0) || d[29]);
    return {d[63], m[30:0] + 31'(rnd)};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    return real2sp(sp2real(a) * sp2real(b));
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return real2sp(sp2real(a) + sp2real(b));
  endfunction

  // Reference: truncated Taylor series of cos in x^2, evaluated by Horner.
  function automatic logic [31:0] cos_ref(input logic [31:0] x);
    logic [31:0] x2, acc;
    x2 = fmul(x, x);
`ifdef COS_TAYLOR_SCHED_TERM3_EN
    acc = fadd(fmul(C3, x2), C2);
    acc = fadd(fmul(acc, x2), C1);
`else
    acc = fadd(fmul(C2, x2), C1);
`endif
    acc = fadd(fmul(acc, x2), One);
    return acc;
  endfunction

  function automatic int ulp_diff(input logic [31:0] a, input logic [31:0] b);
    int d;
    if (a[31] != b[31]) return 1 << 30;
    d = int'(a[30:0]) - int'(b[30:0]);
    return (d < 0) ? -d : d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_tol(input string name, input logic [31:0] act, input logic [31:0] exp,
                         input int tol);
    checks++;
    if (ulp_diff(act, exp) > tol) begin
      errors++;
      $display("FAIL %s: got %h expected %h within %0d ulp", name, act, exp, tol);
    end
  endtask

  // ---------------- unit models: ack after a_dly/b_dly, result after latency
  int          m_ac, m_bc, m_lc, a_ac, a_bc, a_lc;
  bit          m_ah, m_bh, a_ah, a_bh;
  logic [31:0] m_ra, m_rb, a_ra, a_rb;

  always @(posedge clk) begin
    if (!rst) begin
      mul_a_ack <= 1'b0; mul_b_ack <= 1'b0; mul_z_stb <= 1'b0;
      m_ac <= 0; m_bc <= 0; m_lc <= 0; m_ah <= 1'b0; m_bh <= 1'b0;
    end else begin
      mul_a_ack <= 1'b0;
      mul_b_ack <= 1'b0;
      if (mul_a_stb && !m_ah) begin
        if (m_ac >= a_dly) begin mul_a_ack <= 1'b1; m_ah <= 1'b1; m_ra <= mul_a; m_ac <= 0; end
        else m_ac <= m_ac + 1;
      end
      if (mul_b_stb && !m_bh) begin
        if (m_bc >= b_dly) begin mul_b_ack <= 1'b1; m_bh <= 1'b1; m_rb <= mul_b; m_bc <= 0; end
        else m_bc <= m_bc + 1;
      end
      if (m_ah && m_bh && !mul_z_stb) begin
        if (m_lc >= MulLat - 1) begin mul_z_stb <= 1'b1; mul_z <= fmul(m_ra, m_rb); m_lc <= 0; end
        else m_lc <= m_lc + 1;
      end
      if (mul_z_stb && mul_z_ack) begin mul_z_stb <= 1'b0; m_ah <= 1'b0; m_bh <= 1'b0; end
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      add_a_ack <= 1'b0; add_b_ack <= 1'b0; add_z_stb <= 1'b0;
      a_ac <= 0; a_bc <= 0; a_lc <= 0; a_ah <= 1'b0; a_bh <= 1'b0;
    end else begin
      add_a_ack <= 1'b0;
      add_b_ack <= 1'b0;
      if (add_a_stb && !a_ah) begin
        if (a_ac >= a_dly) begin add_a_ack <= 1'b1; a_ah <= 1'b1; a_ra <= add_a; a_ac <= 0; end
        else a_ac <= a_ac + 1;
      end
      if (add_b_stb && !a_bh) begin
        if (a_bc >= b_dly) begin add_b_ack <= 1'b1; a_bh <= 1'b1; a_rb <= add_b; a_bc <= 0; end
        else a_bc <= a_bc + 1;
      end
      if (a_ah && a_bh && !add_z_stb) begin
        if (a_lc >= AddLat - 1) begin add_z_stb <= 1'b1; add_z <= fadd(a_ra, a_rb); a_lc <= 0; end
        else a_lc <= a_lc + 1;
      end
      if (add_z_stb && add_z_ack) begin add_z_stb <= 1'b0; a_ah <= 1'b0; a_bh <= 1'b0; end
    end
  end

  // ---------------- protocol monitor -----------------------------------
  bit p_maa, p_mba, p_aaa, p_aba;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (p_maa) chk("mul_a_stb_drop", {31'b0, mul_a_stb}, 32'd0);
      if (p_mba) chk("mul_b_stb_drop", {31'b0, mul_b_stb}, 32'd0);
      if (p_aaa) chk("add_a_stb_drop", {31'b0, add_a_stb}, 32'd0);
      if (p_aba) chk("add_b_stb_drop", {31'b0, add_b_stb}, 32'd0);
      if (mul_a_ack) chk("mul_a_stb_at_ack", {31'b0, mul_a_stb}, 32'd1);
      if (mul_b_ack) chk("mul_b_stb_at_ack", {31'b0, mul_b_stb}, 32'd1);
      if (add_a_ack) chk("add_a_stb_at_ack", {31'b0, add_a_stb}, 32'd1);
      if (add_b_ack) chk("add_b_stb_at_ack", {31'b0, add_b_stb}, 32'd1);
      if ((mul_a_stb || mul_b_stb || mul_z_ack) && (add_a_stb || add_b_stb || add_z_ack))
        chk("one_unit_active", 32'd1, 32'd0);
      if (mul_z_ack) begin chk("mul_zack_needs_stb", {31'b0, mul_z_stb}, 32'd1); zacks++; end
      if (add_z_ack) begin chk("add_zack_needs_stb", {31'b0, add_z_stb}, 32'd1); zacks++; end
      p_maa = mul_a_ack; p_mba = mul_b_ack; p_aaa = add_a_ack; p_aba = add_b_ack;
    end else begin
      p_maa = 1'b0; p_mba = 1'b0; p_aaa = 1'b0; p_aba = 1'b0;
    end
  end

  // ---------------- transaction task -----------------------------------
  // hold: cycles out_ready stays low after out_valid; poke: offer another
  // angle during the hold, which must be ignored.
  task automatic run_op(input logic [31:0] r, input int hold, input bit poke,
                        output logic [31:0] res, output bit ok);
    int n;
    logic [31:0] held;
    ok  = 1'b0;
    res = '0;
    @(negedge clk);
    in_valid = 1'b1;
    rad      = r;
    chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    zacks = 0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("busy_after_accept", {31'b0, busy}, 32'd1);
    chk("no_stb_in_load", {30'b0, mul_a_stb, mul_b_stb}, 32'd0);
    @(negedge clk);
    chk("stb_at_T2", {30'b0, mul_a_stb, mul_b_stb}, 32'd3);
    n = 0;
    while (!out_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      chk("out_valid_timeout", 32'd0, 32'd1);
      return;
    end
    ok   = 1'b1;
    res  = cosine;
    held = cosine;
    chk("zack_count", zacks, NOps);
    for (int i = 0; i < hold; i++) begin
      if (poke) begin in_valid = 1'b1; rad = 32'h40000000; end
      @(negedge clk);
      chk("hold_cosine", cosine, held);
      chk("hold_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_after_ready", {30'b0, out_valid, busy}, 32'd0);
    chk("in_ready_after", {31'b0, in_ready}, 32'd1);
    if (poke) begin
      repeat (3) begin
        @(negedge clk);
        chk("poke_ignored", {31'b0, busy}, 32'd0);
      end
    end
  endtask

  typedef struct {
    logic [31:0] rad;
    int          a_dly;
    int          b_dly;
    logic [31:0] exp_cos;
    int          tol;
  } vec_t;

  vec_t        vecs[5];
  logic [31:0] res, c1, c2, r;
  bit          ok;
  int          n, dcyc;

  initial begin
    vecs[0] = '{32'h00000000, 0, 0, One,  0};  // cos 0 is exactly one
    vecs[1] = '{32'h3f800000, 3, 0, Cos1, 2};  // b_ack 3 cycles before a_ack
    vecs[2] = '{32'h3f800000, 0, 3, Cos1, 2};  // a_ack first
    vecs[3] = '{32'h3f800000, 1, 1, Cos1, 2};  // both together
    vecs[4] = '{32'hbf800000, 2, 2, Cos1, 2};

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; rad = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_outs", {29'b0, out_valid, busy, mul_z_ack | add_z_ack}, 32'd0);
    chk("rst_cosine", cosine, 32'd0);
    chk("rst_stbs", {28'b0, mul_a_stb, mul_b_stb, add_a_stb, add_b_stb}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    foreach (vecs[i]) begin
      a_dly = vecs[i].a_dly;
      b_dly = vecs[i].b_dly;
      run_op(vecs[i].rad, 0, 1'b0, res, ok);
      if (ok) begin
        chk_tol("vec_cosine", res, vecs[i].exp_cos, vecs[i].tol);
        chk("vec_model", res, cos_ref(vecs[i].rad));
      end
    end

    // Backpressure: 10 cycles without out_ready while another angle is offered.
    a_dly = 1; b_dly = 0;
    run_op(32'h3f000000, 10, 1'b1, res, ok);
    if (ok) chk("bp_cosine", res, cos_ref(32'h3f000000));

    // Reset in the middle of op 2 (first adder op).
    @(negedge clk);
    in_valid = 1'b1; rad = 32'h3f800000;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!add_a_stb && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reached_step2", {31'b0, add_a_stb}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("midrst_outs", {29'b0, out_valid, busy, mul_z_ack | add_z_ack}, 32'd0);
    chk("midrst_cosine", cosine, 32'd0);
    chk("midrst_stbs", {28'b0, mul_a_stb, mul_b_stb, add_a_stb, add_b_stb}, 32'd0);
    run_op(32'h00000000, 0, 1'b0, res, ok);
    if (ok) chk("midrst_cos0", res, One);

    // Back-to-back: +1.0 then -1.0 with out_ready held high.
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; rad = 32'h3f800000;
    @(posedge clk);
    @(negedge clk);
    rad = 32'hbf800000;
    n = 0;
    while (!out_valid && n < 400) begin @(negedge clk); n++; end
    chk("b2b_first_valid", {31'b0, out_valid}, 32'd1);
    c1   = cosine;
    dcyc = cyc;
    chk("b2b_no_accept_in_done", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    chk("b2b_accept_next", {31'b0, in_ready}, 32'd1);
    chk("b2b_accept_cycle", cyc - dcyc, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_second_busy", {31'b0, busy}, 32'd1);
    n = 0;
    while (!out_valid && n < 400) begin @(negedge clk); n++; end
    chk("b2b_second_valid", {31'b0, out_valid}, 32'd1);
    c2 = cosine;
    chk("b2b_even", c2, c1);
    chk("b2b_model", c1, cos_ref(32'h3f800000));
    @(negedge clk);
    out_ready = 1'b0;

    // Random angles with random ack skew, exact against the reference model.
    for (int i = 0; i < 16; i++) begin
      r     = {1'($urandom), 8'($urandom_range(110, 128)), 23'($urandom)};
      a_dly = $urandom_range(0, 3);
      b_dly = $urandom_range(0, 3);
      run_op(r, $urandom_range(0, 2), 1'b0, res, ok);
      if (ok) chk("rand_cosine", res, cos_ref(r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
